// File: rtl/leiwand_rv32_wb_interconnect.sv
// leiwand_rv32_wb_interconnect
// Single-master, N-slave Wishbone interconnect with base/mask address decode.
// It tracks one outstanding transaction and routes the selected slave's
// stall, ack and read data back to the core. Unmapped or hung accesses end
// in a one-cycle bus error, and a saturating error counter is kept for debug.
module leiwand_rv32_wb_interconnect #(
  parameter int MEM_WIDTH = 32,
  parameter int NR_SLAVES = 4,
  parameter logic [NR_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NR_SLAVES*MEM_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [MEM_WIDTH-1:0]           wb_addr,
  input  logic                           wb_stb,
  input  logic                           wb_cyc,
  input  logic                           wb_we,
  output logic                           wb_ack,
  output logic                           wb_err,
  output logic                           wb_stall,
  output logic [MEM_WIDTH-1:0]           wb_data_in,
  output logic [NR_SLAVES-1:0]           s_stb,
  input  logic [NR_SLAVES-1:0]           s_ack,
  input  logic [NR_SLAVES-1:0]           s_stall,
  input  logic [NR_SLAVES*MEM_WIDTH-1:0] s_data,
  output logic [7:0]                     err_count
);

  localparam int SEL_W = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  // Last counter value that still waits for an ack before giving up
  localparam logic [15:0] TMO_LAST = (TIMEOUT_CYCLES != 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  logic [1:0]       state_reg, state_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [15:0]      tmo_reg, tmo_next;
  logic [7:0]       errc_reg, errc_next;

  logic [NR_SLAVES-1:0] hit;
  logic [NR_SLAVES-1:0] hit_onehot;
  logic                 hit_any;
  logic [SEL_W-1:0]     hit_idx;
  logic                 hit_stall;
  logic                 sel_ack;
  logic [MEM_WIDTH-1:0] sel_data;

  // The write enable is broadcast to the slaves at SoC level; this block never needs it
  logic unused_we;
  assign unused_we = wb_we;

  // Per-slave address match; a zero mask leaves the slave permanently unmapped
  genvar gi;
  generate
    for (gi = 0; gi < NR_SLAVES; gi++) begin : g_dec
      localparam logic [MEM_WIDTH-1:0] BASE = SLAVE_BASE[gi*MEM_WIDTH +: MEM_WIDTH];
      localparam logic [MEM_WIDTH-1:0] MASK = SLAVE_MASK[gi*MEM_WIDTH +: MEM_WIDTH];
      assign hit[gi] = (MASK != '0) && ((wb_addr & MASK) == BASE);
    end
  endgenerate

  assign hit_any = |hit;

  // Lowest-index priority encoder over the address hits
  always_comb begin
    hit_idx = '0;
    for (int i = NR_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Muxes for the decoded slave (stall, strobe) and the latched slave (ack, data)
  always_comb begin
    hit_onehot = '0;
    hit_stall  = 1'b0;
    sel_ack    = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < NR_SLAVES; i++) begin
      if (hit_idx == SEL_W'(i)) begin
        hit_onehot[i] = hit_any;
        hit_stall     = s_stall[i];
      end
      if (sel_reg == SEL_W'(i)) begin
        sel_ack  = s_ack[i];
        sel_data = s_data[i*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

  // Transaction FSM: next state and all master/slave facing outputs
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    tmo_next   = tmo_reg;
    errc_next  = errc_reg;
    s_stb      = '0;
    wb_ack     = 1'b0;
    wb_err     = 1'b0;
    wb_stall   = 1'b1;
    wb_data_in = '0;
    case (state_reg)
      ST_IDLE: begin
        wb_stall = 1'b0;
        if (wb_stb && wb_cyc) begin
          if (hit_any) begin
            s_stb    = hit_onehot;
            wb_stall = hit_stall;
            if (!hit_stall) begin
              sel_next   = hit_idx;
              tmo_next   = '0;
              state_next = ST_BUSY;
            end
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        wb_data_in = sel_data;
        if (!wb_cyc) begin
          // Master gave up the cycle: drop the transaction silently
          state_next = ST_IDLE;
        end else if (sel_ack) begin
          wb_ack     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          if (tmo_reg != 16'hFFFF) begin
            tmo_next = tmo_reg + 16'd1;
          end
          if ((TIMEOUT_CYCLES != 0) && (tmo_reg == TMO_LAST)) begin
            state_next = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        wb_err     = 1'b1;
        state_next = ST_IDLE;
        if (errc_reg != 8'hFF) begin
          errc_next = errc_reg + 8'd1;
        end
      end
      ST_ABORT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // Hold the bus quiet while reset is asserted
    if (!RST) begin
      s_stb      = '0;
      wb_ack     = 1'b0;
      wb_err     = 1'b0;
      wb_stall   = 1'b1;
      wb_data_in = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      sel_reg   <= '0;
      tmo_reg   <= '0;
      errc_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      tmo_reg   <= tmo_next;
      errc_reg  <= errc_next;
    end
  end

  assign err_count = errc_reg;

endmodule

// File: doc/leiwand_rv32_wb_interconnect.md
# leiwand_rv32_wb_interconnect

Parametrised single-master, N-slave Wishbone interconnect placed between `leiwand_rv32_core` and the SoC peripherals (internal RAM/ROM, GPIO, UART, …). It replaces hard-wired single-bit slave selection with a base/mask address decoder. It tracks one outstanding transaction, routes the ack, stall and read data of the selected slave back to the core, and terminates unmapped or hung accesses with a bus error. It also keeps a saturating error counter for debug.

## Interface
- `MEM_WIDTH`, 32, address/data width.
- `NR_SLAVES`, 4, number of slave ports (1..8).
- `SLAVE_BASE`, 0, packed `NR_SLAVES*MEM_WIDTH`; slice i is the base address of slave i.
- `SLAVE_MASK`, 0, packed `NR_SLAVES*MEM_WIDTH`; slice i is the address mask of slave i. A mask of 0 disables the slave.
- `TIMEOUT_CYCLES`, 255, maximum wait for a slave ack in cycles; 0 disables the timeout.
- `CLK` in 1: system clock; all logic is on the rising edge.
- `RST` in 1: synchronous, active-low reset.
- `wb_addr` in MEM_WIDTH: master address.
- `wb_stb` in 1: master strobe.
- `wb_cyc` in 1: master cycle.
- `wb_we` in 1: master write enable.
- `wb_ack` out 1: ack to master.
- `wb_err` out 1: bus error to master (one-cycle pulse).
- `wb_stall` out 1: stall to master.
- `wb_data_in` out MEM_WIDTH: read data to master.
- `s_stb` out NR_SLAVES: one-hot slave strobes.
- `s_ack` in NR_SLAVES: slave acks.
- `s_stall` in NR_SLAVES: slave stalls.
- `s_data` in NR_SLAVES*MEM_WIDTH: packed slave read data.
- `err_count` out 8: saturating count of bus errors.

`wb_addr`, `wb_data_out`, `wb_we`, `wb_cyc` and `data_write_size` are broadcast to all slaves at SoC level and are not routed through this block.

## Operation
- Decode: slave i hits when `(wb_addr & MASK_i) == BASE_i` and `MASK_i != 0`. When several slaves hit, the lowest index wins. `hit_any` = OR of all hits.
- The FSM has four states: IDLE, BUSY, ERR, ABORT. Registers are `state`, `sel` (`$clog2(NR_SLAVES)` bits), `tmo_cnt` (16 bits) and `err_count`.
- **IDLE**
  - `wb_stb & wb_cyc & hit_any`:
    - `s_stb[hit]=1` combinationally.
    - `wb_stall = s_stall[hit]`.
    - If not stalled, the request is accepted: `sel<=hit`, `tmo_cnt<=0`, next state BUSY.
  - `wb_stb & wb_cyc & !hit_any`:
    - `wb_stall=0`; the request is accepted.
    - Next state ERR.
  - Otherwise: `wb_stall=0`, `s_stb=0`.
- **BUSY**
  - `s_stb=0`, `wb_stall=1`.
  - `wb_ack = s_ack[sel]` and `wb_data_in = s_data[sel]`, both combinational.
  - `s_ack[sel]` → next state IDLE.
  - Acks from non-selected slaves are ignored.
  - With no ack, `tmo_cnt` increments. When `TIMEOUT_CYCLES != 0` and `tmo_cnt == TIMEOUT_CYCLES-1` without an ack, the next state is ERR.
  - `wb_cyc` low → next state IDLE with no ack and no err (master abort).
- **ERR**
  - `wb_err=1` and `wb_stall=1` for exactly one cycle.
  - `err_count` increments, saturating at 255.
  - Next state IDLE.
- **ABORT** is reserved. It maps to IDLE and is unreachable.
- `wb_data_in` is 0 in every state except BUSY.
- `wb_ack` and `wb_err` are never high in the same cycle.

## Timing
- While `RST` is low (sampled at the edge):
  - `state=IDLE`, `sel=0`, `tmo_cnt=0`, `err_count=0`.
  - Combinational outputs are forced while `RST` is low: `s_stb=0`, `wb_ack=0`, `wb_err=0`, `wb_stall=1`, `wb_data_in=0`.
- Reset asserted mid-transaction drops the transaction with no ack and no err. The slave ack that may follow is ignored.
- Strobe path: slave strobe in the same cycle as master strobe; zero added latency.
- Ack path: master ack in the same cycle as slave ack. The earliest master ack is one cycle after acceptance.
- Unmapped access: `wb_err` in the cycle after acceptance.
- Timeout: `wb_err` asserts `TIMEOUT_CYCLES+1` cycles after acceptance.
- Back-to-back: a new request can be accepted in the cycle after `wb_ack`/`wb_err`. The core must keep `wb_stb` high until it is accepted.
- A slave stalled in IDLE holds `s_stb` high and `wb_stall` high until `s_stall` drops, with no timeout while stalled.

## Test plan
1. **Reset values.** `RST=0` for 3 cycles with `wb_stb=1`.
   - Required: `s_stb=0`, `wb_stall=1`, `wb_ack=0`, `err_count=0`.
2. **Decode, read data and priority.** Configuration: `NR_SLAVES=2`, `BASE0=0x20400000/MASK0=0xFFC00000`, `BASE1=0x10000000/MASK1=0xFFFFF000`. Read `0x20400008`; slave 0 acks one cycle later with `0xDEADBEEF`.
   - Required: `s_stb=2'b01`; `wb_ack=1` and `wb_data_in=0xDEADBEEF` in the ack cycle.
   - Set slave 1 to overlap slave 0.
   - Required: slave 0 is still selected.
3. **Unmapped address.** Access `0x00000000`.
   - Required: `s_stb=0`, `wb_err=1` exactly one cycle later, `err_count=1`.
   - Repeat 300 times.
   - Required: `err_count` saturates at 255.
4. **Timeout.** `TIMEOUT_CYCLES=4`; slave never acks.
   - Required: `wb_err` on cycle 5 after acceptance, then IDLE. A late `s_ack` afterwards gives no `wb_ack`.
5. **Stall and abort.** `s_stall[0]=1` for 3 cycles.
   - Required: `wb_stall=1` and `s_stb[0]=1` throughout; acceptance on cycle 4.
   - Drop `wb_cyc` while BUSY.
   - Required: return to IDLE, no ack, no err.
6. **Back-to-back.** Two accesses to slave 1, each acked 1 cycle after acceptance.
   - Required: the second access is accepted the cycle after the first `wb_ack`, giving 2 acks in 4 cycles.
